// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC and fetches one instruction per phase_fetch pulse
// over a req/ack instruction-memory handshake, presenting the result to decode.
module instruction_fetch #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]     NOP_INST     = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            phase_fetch,
  input  logic            pc_we,
  input  logic [XLEN-1:0] pc_wdata,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic [XLEN-1:0] next_pc_fd,
  output logic            stall_fetch,
  output logic            misalign_err
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            start_fetch;
  logic            fetch_done;
  logic [XLEN-1:0] pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    start_fetch = 1'b0;
    fetch_done  = 1'b0;
    case (state)
      IDLE: begin
        if (phase_fetch) begin
          next_state  = REQ;
          start_fetch = 1'b1;
        end
      end
      REQ: begin
        if (imem_ack) begin
          next_state = IDLE;
          fetch_done = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Deriving req from the state register lets an async reset drop it at once.
  assign imem_req    = (state == REQ);
  assign stall_fetch = (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_VECTOR;
      misalign_err <= 1'b0;
    end else if (pc_we) begin
      pc <= {pc_wdata[XLEN-1:2], 2'b00};
      if (pc_wdata[1:0] != 2'b00) begin
        misalign_err <= 1'b1;
      end
    end
  end

  // imem_addr captures the pre-edge pc, so a redirect in the same cycle
  // as the fetch pulse only affects the following fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr  <= RESET_VECTOR;
      inst       <= NOP_INST;
      curr_pc_fd <= RESET_VECTOR;
      next_pc_fd <= RESET_VECTOR + XLEN'(4);
    end else begin
      if (start_fetch) begin
        imem_addr <= pc;
      end
      if (fetch_done) begin
        inst       <= imem_rdata;
        curr_pc_fd <= imem_addr;
        next_pc_fd <= imem_addr + XLEN'(4);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: handshake latency, wait states, PC
// redirects, misalignment, spurious handshake inputs and async reset.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        phase_fetch;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] curr_pc_fd;
  logic [31:0] next_pc_fd;
  logic        stall_fetch;
  logic        misalign_err;

  int checks;
  int failures;

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .phase_fetch (phase_fetch),
    .pc_we       (pc_we),
    .pc_wdata    (pc_wdata),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .curr_pc_fd  (curr_pc_fd),
    .next_pc_fd  (next_pc_fd),
    .stall_fetch (stall_fetch),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (inst !== 32'h0000_0013 || curr_pc_fd !== 32'h0 || next_pc_fd !== 32'h4) begin
      failures++;
      $display("FAIL reset_outputs: inst=%h curr=%h next=%h, want 00000013 00000000 00000004",
               inst, curr_pc_fd, next_pc_fd);
    end
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || stall_fetch !== 1'b0 || misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: req=%b addr=%h stall=%b mis=%b, want 0 00000000 0 0",
               imem_req, imem_addr, stall_fetch, misalign_err);
    end
    rst_n = 1'b1;
    tick();
    $display("reset: inst=%h curr=%h next=%h", inst, curr_pc_fd, next_pc_fd);
  endtask

  task automatic test_min_latency();
    int stall_cycles;
    stall_cycles = 0;
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h0050_0093;
    @(negedge clk);
    if (stall_fetch === 1'b1) stall_cycles++;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL min_lat_req: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    if (stall_fetch === 1'b1) stall_cycles++;
    checks++;
    if (inst !== 32'h0050_0093 || curr_pc_fd !== 32'h0 || next_pc_fd !== 32'h4) begin
      failures++;
      $display("FAIL min_lat_result: inst=%h curr=%h next=%h, want 00500093 00000000 00000004",
               inst, curr_pc_fd, next_pc_fd);
    end
    checks++;
    if (stall_cycles != 1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL min_lat_stall: stall_cycles=%0d req=%b, want 1 0", stall_cycles, imem_req);
    end
    $display("min_latency: inst=%h curr=%h next=%h stall_cycles=%0d", inst, curr_pc_fd, next_pc_fd, stall_cycles);
  endtask

  task automatic test_wait_states();
    int stall_cycles;
    int hold_bad;
    stall_cycles = 0;
    hold_bad     = 0;
    pc_we    = 1'b1;
    pc_wdata = 32'h100;
    tick();
    pc_we       = 1'b0;
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    imem_rdata  = 32'h00A0_0113;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3);
      @(negedge clk);
      if (stall_fetch === 1'b1) stall_cycles++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst !== 32'h0050_0093 ||
          curr_pc_fd !== 32'h0 || next_pc_fd !== 32'h4) hold_bad++;
      tick();
    end
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (hold_bad != 0 || stall_cycles != 4) begin
      failures++;
      $display("FAIL wait_hold: bad_cycles=%0d stall_cycles=%0d, want 0 4", hold_bad, stall_cycles);
    end
    checks++;
    if (inst !== 32'h00A0_0113 || curr_pc_fd !== 32'h100 || next_pc_fd !== 32'h104 || stall_fetch !== 1'b0) begin
      failures++;
      $display("FAIL wait_result: inst=%h curr=%h next=%h stall=%b, want 00a00113 00000100 00000104 0",
               inst, curr_pc_fd, next_pc_fd, stall_fetch);
    end
    $display("wait_states: inst=%h curr=%h next=%h stall_cycles=%0d", inst, curr_pc_fd, next_pc_fd, stall_cycles);
  endtask

  task automatic test_redirect_in_req();
    pc_we    = 1'b1;
    pc_wdata = 32'h0;
    tick();
    pc_we       = 1'b0;
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    pc_we       = 1'b1;
    pc_wdata    = 32'h200;
    tick();
    pc_we      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL redirect_addr_hold: addr=%h req=%b, want 00000000 1", imem_addr, imem_req);
    end
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (curr_pc_fd !== 32'h0 || next_pc_fd !== 32'h4 || inst !== 32'h1111_1111) begin
      failures++;
      $display("FAIL redirect_old_pc: curr=%h next=%h inst=%h, want 00000000 00000004 11111111",
               curr_pc_fd, next_pc_fd, inst);
    end
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h2222_2222;
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'h200) begin
      failures++;
      $display("FAIL redirect_new_addr: addr=%h, want 00000200", imem_addr);
    end
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (curr_pc_fd !== 32'h200 || next_pc_fd !== 32'h204) begin
      failures++;
      $display("FAIL redirect_new_result: curr=%h next=%h, want 00000200 00000204", curr_pc_fd, next_pc_fd);
    end
    $display("redirect_in_req: curr=%h next=%h", curr_pc_fd, next_pc_fd);
  endtask

  task automatic test_misalign_wrap();
    checks++;
    if (misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pre: mis=%b, want 0", misalign_err);
    end
    pc_we    = 1'b1;
    pc_wdata = 32'hFFFF_FFFE;
    tick();
    pc_we       = 1'b0;
    phase_fetch = 1'b1;
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b1) begin
      failures++;
      $display("FAIL misalign_set: mis=%b, want 1", misalign_err);
    end
    tick();
    phase_fetch = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h3333_3333;
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL misalign_addr: addr=%h, want fffffffc", imem_addr);
    end
    tick();
    imem_ack = 1'b0;
    pc_we    = 1'b1;
    pc_wdata = 32'h300;
    @(negedge clk);
    checks++;
    if (curr_pc_fd !== 32'hFFFF_FFFC || next_pc_fd !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next: curr=%h next=%h, want fffffffc 00000000", curr_pc_fd, next_pc_fd);
    end
    tick();
    pc_we = 1'b0;
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b1) begin
      failures++;
      $display("FAIL misalign_sticky: mis=%b, want 1", misalign_err);
    end
    $display("misalign_wrap: curr=%h next=%h mis=%b", curr_pc_fd, next_pc_fd, misalign_err);
  endtask

  task automatic test_spurious();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (inst !== 32'h3333_3333 || curr_pc_fd !== 32'hFFFF_FFFC || stall_fetch !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL spurious_ack: inst=%h curr=%h stall=%b req=%b, want 33333333 fffffffc 0 0",
               inst, curr_pc_fd, stall_fetch, imem_req);
    end
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h4444_4444;
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'h300 || imem_req !== 1'b1 || inst !== 32'h3333_3333) begin
      failures++;
      $display("FAIL spurious_phase: addr=%h req=%b inst=%h, want 00000300 1 33333333",
               imem_addr, imem_req, inst);
    end
    tick();
    imem_ack = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (stall_fetch !== 1'b0 || inst !== 32'h4444_4444 || curr_pc_fd !== 32'h300) begin
      failures++;
      $display("FAIL spurious_no_queue: stall=%b inst=%h curr=%h, want 0 44444444 00000300",
               stall_fetch, inst, curr_pc_fd);
    end
    $display("spurious: inst=%h curr=%h stall=%b", inst, curr_pc_fd, stall_fetch);
  endtask

  task automatic test_reset_mid_req();
    phase_fetch = 1'b1;
    tick();
    phase_fetch = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h5555_5555;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || stall_fetch !== 1'b0 || inst !== 32'h0000_0013 ||
        curr_pc_fd !== 32'h0 || next_pc_fd !== 32'h4) begin
      failures++;
      $display("FAIL reset_mid_req: req=%b stall=%b inst=%h curr=%h next=%h, want 0 0 00000013 00000000 00000004",
               imem_req, stall_fetch, inst, curr_pc_fd, next_pc_fd);
    end
    #1;
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (inst !== 32'h0000_0013 || stall_fetch !== 1'b0 || misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack_dropped: inst=%h stall=%b mis=%b, want 00000013 0 0",
               inst, stall_fetch, misalign_err);
    end
    $display("reset_mid_req: inst=%h req=%b mis=%b", inst, imem_req, misalign_err);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    phase_fetch = 1'b0;
    pc_we       = 1'b0;
    pc_wdata    = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    test_reset();
    test_min_latency();
    test_wait_states();
    test_redirect_in_req();
    test_misalign_wrap();
    test_spurious();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
